ps2_key_tracker: RTL

- Consumes the scan-code byte stream from the PS/2 receiver FIFO (ready / nextdata_n handshake).
- Decodes set-2 prefixes: E0 marks an extended key, F0 marks a break.
- Keeps a table of up to MAX_KEYS simultaneously held keys and counts distinct key presses.
- Emits one-cycle make/break events. Sits between ps2_keyboard and the seven-segment display / ASCII ROM logic.

---
 rtl/ps2_key_tracker.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Pops set-2 scan-code bytes from the PS/2 receiver FIFO. It decodes the
//   E0 (extended) and F0 (break) prefixes and keeps a small table of the
//   keys that are currently held. It emits one-cycle make/break events and
//   counts distinct new key presses.
//
// Ports
//   clk         system clock
//   clrn        synchronous active-low reset
//   ready       receiver FIFO non-empty
//   data        byte at the FIFO head
//   overflow    receiver FIFO overflow flag
//   nextdata_n  active-low pop strobe, low for one cycle after each capture
//   evt_valid   one-cycle event pulse
//   evt_make    1 = make, 0 = break; qualified by evt_valid
//   evt_ext     event key carried an E0 prefix; held until the next event
//   evt_code    event scan code; held until the next event
//   key_down    at least one key held
//   held_cnt    number of held keys
//   press_cnt   accepted new presses, wraps silently
//   drop        one-cycle pulse: a make was lost because the table was full
//   err_ovf     sticky receiver-overflow flag
module ps2_key_tracker #(
    parameter int MAX_KEYS      = 4,
    parameter int CNT_W         = 8,
    parameter bit REPEAT_FILTER = 1'b1
) (
    input  logic                            clk,
    input  logic                            clrn,
    input  logic                            ready,
    input  logic [7:0]                      data,
    input  logic                            overflow,
    output logic                            nextdata_n,
    output logic                            evt_valid,
    output logic                            evt_make,
    output logic                            evt_ext,
    output logic [7:0]                      evt_code,
    output logic                            key_down,
    output logic [$clog2(MAX_KEYS+1)-1:0]   held_cnt,
    output logic [CNT_W-1:0]                press_cnt,
    output logic                            drop,
    output logic                            err_ovf
);

    localparam int HC_W  = $clog2(MAX_KEYS + 1);
    localparam int IDX_W = (MAX_KEYS > 1) ? $clog2(MAX_KEYS) : 1;

    localparam logic [HC_W-1:0]  HC_ONE = HC_W'(1);
    localparam logic [CNT_W-1:0] PC_ONE = CNT_W'(1);
    localparam logic [7:0]       PFX_EXT = 8'hE0;
    localparam logic [7:0]       PFX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_SETTLE
    } state_t;

    state_t state, state_nxt;

    // Prefix flags collected since the last code byte.
    logic ext_pend, brk_pend;

    // Held-key table: valid bit plus {ext, code} per slot.
    logic [MAX_KEYS-1:0] tbl_vld;
    logic [8:0]          tbl_key [MAX_KEYS];

    logic             capture, is_code;
    logic [8:0]       cur_key;
    logic             hit, free_ok;
    logic [IDX_W-1:0] hit_idx, free_idx;
    logic             do_insert, do_remove;

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: every clocked register uses non-blocking assignment so all
        // state updates see the same pre-edge values.
        if (!clrn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        state_nxt  = state;
        nextdata_n = 1'b1;
        case (state)
            S_IDLE:   if (ready) state_nxt = S_POP;
            S_POP: begin
                nextdata_n = 1'b0;
                state_nxt  = S_SETTLE;
            end
            // The receiver's read pointer moves during this cycle, so ready
            // is not trusted until we are back in IDLE.
            S_SETTLE: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign capture = (state == S_IDLE) && ready;
    assign is_code = capture && (data != PFX_EXT) && (data != PFX_BRK);
    assign cur_key = {ext_pend, data};

    // ------------------------------------------------------------------
    // Associative lookup and lowest free slot
    // ------------------------------------------------------------------
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free_ok  = 1'b0;
        free_idx = '0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            if (tbl_vld[i] && (tbl_key[i] == cur_key)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
        // Scan downwards so the last assignment is the lowest free index.
        for (int i = MAX_KEYS - 1; i >= 0; i--) begin
            if (!tbl_vld[i]) begin
                free_ok  = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign do_insert = is_code && !brk_pend && !hit && free_ok;
    assign do_remove = is_code &&  brk_pend &&  hit;

    // Key payload carries no meaning unless its valid bit is set.
    always_ff @(posedge clk) begin
        // NOTE: table contents are not reset; clearing tbl_vld is enough.
        if (do_insert) tbl_key[free_idx] <= cur_key;
    end

    // ------------------------------------------------------------------
    // Control and event registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clrn) begin
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            tbl_vld   <= '0;
            held_cnt  <= '0;
            key_down  <= 1'b0;
            press_cnt <= '0;
            evt_valid <= 1'b0;
            evt_make  <= 1'b0;
            evt_ext   <= 1'b0;
            evt_code  <= '0;
            drop      <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            evt_valid <= 1'b0;
            drop      <= 1'b0;
            if (overflow) err_ovf <= 1'b1;

            if (capture && (data == PFX_EXT)) ext_pend <= 1'b1;
            if (capture && (data == PFX_BRK)) brk_pend <= 1'b1;

            if (is_code) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
                if (brk_pend) begin
                    // A break is always reported, held or not.
                    evt_valid <= 1'b1;
                    evt_make  <= 1'b0;
                    evt_ext   <= ext_pend;
                    evt_code  <= data;
                    if (hit) begin
                        tbl_vld[hit_idx] <= 1'b0;
                        held_cnt         <= held_cnt - HC_ONE;
                        key_down         <= (held_cnt != HC_ONE);
                    end
                end else if (hit) begin
                    // Typematic repeat: never counted, optionally reported.
                    if (!REPEAT_FILTER) begin
                        evt_valid <= 1'b1;
                        evt_make  <= 1'b1;
                        evt_ext   <= ext_pend;
                        evt_code  <= data;
                    end
                end else if (free_ok) begin
                    tbl_vld[free_idx] <= 1'b1;
                    held_cnt          <= held_cnt + HC_ONE;
                    key_down          <= 1'b1;
                    press_cnt         <= press_cnt + PC_ONE;
                    evt_valid         <= 1'b1;
                    evt_make          <= 1'b1;
                    evt_ext           <= ext_pend;
                    evt_code          <= data;
                end else begin
                    drop <= 1'b1;
                end
            end
        end
    end

endmodule
